// File: rtl/bg_scene_scheduler.sv
// -----------------------------------------------------------------------------
// bg_scene_scheduler
//
// Scene configuration for the chroma-key display path. Chooses the background
// ROM index (rand_ball) and the upscale mode. Changes are applied only at the
// first blanking line of a frame, so a frame never shows two scenes. Game
// logic starts a round with a rising edge on new_round_req. The round ends
// after ROUND_FRAMES frame boundaries.
//
// Optional build macro: BG_AUTO_RESHUFFLE_EN
//   When defined, an expiring round does not end. A fresh background is
//   picked and the frame counter reloads.
//
// Ports:
//   clk            system/pixel clock
//   reset          synchronous, active-high
//   x_pixel        VGA horizontal counter (not needed for boundary detection)
//   y_pixel        VGA vertical counter; the 479->480 step marks the boundary
//   DE             display enable (not used for boundary detection)
//   new_round_req  round request; the rising edge is the event
//   upscale_req    requested upscale mode (level)
//   rand_ball      background ROM select
//   upscale        applied upscale mode
//   new_round_ack  one-cycle pulse when a requested round takes effect
//   frame_start    one-cycle pulse when the configuration registers update
//   round_active   high while a round is running
//   frames_left    frames remaining in the current round
// -----------------------------------------------------------------------------
module bg_scene_scheduler #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          NUM_BALLS    = 3,
  parameter int          ROUND_FRAMES = 300,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       DE,
  input  logic       new_round_req,
  input  logic       upscale_req,
  output logic [1:0] rand_ball,
  output logic       upscale,
  output logic       new_round_ack,
  output logic       frame_start,
  output logic       round_active,
  output logic [8:0] frames_left
);

  typedef enum logic [1:0] {IDLE, PENDING, ROUND} state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [8:0]  RELOAD   = 9'(ROUND_FRAMES - 1);
  localparam logic [2:0]  NB3      = 3'(NUM_BALLS);
  localparam logic [1:0]  BALL_MAX = 2'(NUM_BALLS - 1);

  // Horizontal position and DE are not needed: the vertical step is enough.
  logic unused_ok;
  assign unused_ok = &{1'b0, DE, x_pixel, (x_pixel < 10'(H_ACTIVE))};

  state_t      state_q, state_d;
  logic [9:0]  prev_y;
  logic        req_d;
  logic [15:0] lfsr;
  logic [1:0]  pend_ball, pend_d;
  logic [1:0]  ball_d;
  logic [8:0]  frames_d;
  logic        active_d, ack_d;
  logic        bnd, req_evt;
  logic [2:0]  cand;
  logic [1:0]  next_ball, pick;

  assign bnd     = (y_pixel == 10'(V_ACTIVE)) && (prev_y == 10'(V_ACTIVE - 1));
  assign req_evt = new_round_req & ~req_d;

  // The candidate is folded once into range. The current ball is then skipped
  // so that a new round always changes the scene.
  always_comb begin
    cand      = {1'b0, lfsr[1:0]};
    if (cand >= NB3) cand = cand - NB3;
    next_ball = (rand_ball == BALL_MAX) ? 2'd0 : rand_ball + 2'd1;
    if (NUM_BALLS <= 1)               pick = 2'd0;
    else if (cand[1:0] == rand_ball)  pick = next_ball;
    else                              pick = cand[1:0];
  end

  // NOTE: every variable gets a default before the case. Each path then
  // assigns all of them, so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_ball;
    ball_d   = rand_ball;
    frames_d = frames_left;
    active_d = round_active;
    ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_evt) begin
          pend_d  = pick;
          state_d = PENDING;
        end
      end
      PENDING: begin
        // A second request while pending is ignored on purpose.
        if (bnd) begin
          ball_d   = pend_ball;
          frames_d = RELOAD;
          active_d = 1'b1;
          ack_d    = 1'b1;
          state_d  = ROUND;
        end
      end
      ROUND: begin
        // A request beats a coincident boundary. The new ball waits for the
        // following boundary and the counter freezes.
        if (req_evt) begin
          pend_d  = pick;
          state_d = PENDING;
        end else if (bnd) begin
          if (frames_left != 9'd0) begin
            frames_d = frames_left - 9'd1;
          end else begin
`ifdef BG_AUTO_RESHUFFLE_EN
            ball_d   = pick;
            frames_d = RELOAD;
`else
            active_d = 1'b0;
            state_d  = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req_d follows the input even during reset. A request held across reset
  // therefore does not produce a fresh event afterwards.
  always_ff @(posedge clk) begin
    req_d <= new_round_req;
  end

  // NOTE: state registers use non-blocking assignments, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_y        <= 10'd0;
      lfsr          <= SEED;
      pend_ball     <= 2'd0;
      rand_ball     <= 2'd0;
      upscale       <= 1'b0;
      new_round_ack <= 1'b0;
      frame_start   <= 1'b0;
      round_active  <= 1'b0;
      frames_left   <= 9'd0;
    end else begin
      state_q       <= state_d;
      prev_y        <= y_pixel;
      // Fibonacci taps 16,14,13,11; the sequence is maximal-length.
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      pend_ball     <= pend_d;
      rand_ball     <= ball_d;
      frames_left   <= frames_d;
      round_active  <= active_d;
      new_round_ack <= ack_d;
      frame_start   <= bnd;
      if (bnd) upscale <= upscale_req;
    end
  end

endmodule

// File: tb/tb_bg_scene_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bg_scene_scheduler
//
// Self-checking bench for bg_scene_scheduler. Frames are compressed: each
// "line" lasts only a few clocks, because the design looks only at the
// vertical counter. A reference model predicts the scene that each
// frame_start must present and queues that prediction. A monitor pops and
// compares the prediction whenever the DUT pulses frame_start. Define
// BG_AUTO_RESHUFFLE_EN for both the bench and the RTL to cover the reshuffle
// build.
// -----------------------------------------------------------------------------
module tb_bg_scene_scheduler;

  localparam int NB   = 3;
  localparam int RF   = 3;
  localparam int VA   = 480;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x_pixel = '0;
  logic [9:0] y_pixel = '0;
  logic       de = 1'b0;
  logic       new_round_req = 1'b0;
  logic       upscale_req = 1'b0;
  logic [1:0] rand_ball;
  logic       upscale;
  logic       new_round_ack;
  logic       frame_start;
  logic       round_active;
  logic [8:0] frames_left;

  bg_scene_scheduler #(
    .H_ACTIVE(640), .V_ACTIVE(VA), .NUM_BALLS(NB),
    .ROUND_FRAMES(RF), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .x_pixel(x_pixel), .y_pixel(y_pixel), .DE(de),
    .new_round_req(new_round_req), .upscale_req(upscale_req),
    .rand_ball(rand_ball), .upscale(upscale), .new_round_ack(new_round_ack),
    .frame_start(frame_start), .round_active(round_active),
    .frames_left(frames_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ball;
    int ups;
    int ack;
    int active;
    int frames;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The next LFSR state: shift left and feed in the parity of the tap bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  function automatic int model_pick(input int low2, input int cur);
    int c;
    c = low2;
    if (c >= NB) c = c - NB;
    if (c == cur) c = (cur + 1) % NB;
    return c;
  endfunction

  // ---------------- reference model (scene-level) ----------------
  int          m_prev_y = 0, m_req_d = 0;
  int          m_ball = 0, m_ups = 0, m_active = 0, m_frames = 0;
  int          m_pending = 0, m_pend = 0, m_ack = 0, m_pick = 0;
  bit          m_bnd, m_evt;
  logic [15:0] m_lfsr = SEED;
  exp_t        m_e;

  initial forever begin
    @(posedge clk);
    m_bnd  = (int'(y_pixel) == VA) && (m_prev_y == VA - 1);
    m_evt  = new_round_req && (m_req_d == 0);
    m_pick = model_pick(int'(m_lfsr[1:0]), m_ball);
    if (reset) begin
      m_ball = 0; m_ups = 0; m_active = 0; m_frames = 0;
      m_pending = 0; m_pend = 0;
      m_lfsr = SEED;
      m_prev_y = 0;
    end else begin
      m_ack = 0;
      if (m_evt && !m_pending) begin
        m_pending = 1;
        m_pend    = m_pick;
      end else if (m_bnd) begin
        if (m_pending) begin
          m_ball = m_pend; m_frames = RF - 1; m_active = 1;
          m_ack = 1; m_pending = 0;
        end else if (m_active) begin
          if (m_frames > 0) m_frames = m_frames - 1;
          else begin
`ifdef BG_AUTO_RESHUFFLE_EN
            m_ball = m_pick; m_frames = RF - 1;
`else
            m_active = 0;
`endif
          end
        end
      end
      if (m_bnd) begin
        m_ups = int'(upscale_req);
        m_e.ball = m_ball; m_e.ups = m_ups; m_e.ack = m_ack;
        m_e.active = m_active; m_e.frames = m_frames;
        exp_q.push_back(m_e);
      end
      m_lfsr   = lfsr_next(m_lfsr);
      m_prev_y = int'(y_pixel);
    end
    m_req_d = int'(new_round_req);
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    check("ack_without_frame_start", int'(new_round_ack & ~frame_start), 0);
    check("frame_start_timing", int'(frame_start), (exp_q.size() > 0) ? 1 : 0);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (frame_start) begin
        check("rand_ball",    int'(rand_ball),     mon_e.ball);
        check("upscale",      int'(upscale),       mon_e.ups);
        check("new_round_ack", int'(new_round_ack), mon_e.ack);
        check("round_active", int'(round_active),  mon_e.active);
        check("frames_left",  int'(frames_left),   mon_e.frames);
        check("rand_ball_range", int'(rand_ball < 2'(NB)), 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic line(input int y, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      y_pixel = 10'(y);
      x_pixel = 10'(i * 50);
      de      = (y < VA);
      if (rnd) begin
        if ($urandom_range(0, 15) == 0) new_round_req = ~new_round_req;
        if ($urandom_range(0, 19) == 0) upscale_req = ~upscale_req;
        reset = ($urandom_range(0, 399) == 0);
      end
    end
  endtask

  task automatic frame(input bit rnd, input bit req_at_bnd);
    if (rnd) line(int'($urandom_range(475, 485)), 1, rnd);
    line(0, 3, rnd);
    line(50, 3, rnd);
    line(478, 2, rnd);
    line(479, 3, rnd);
    if (req_at_bnd) begin
      @(negedge clk);
      y_pixel = 10'(VA);
      new_round_req = 1'b1;
      line(VA, 2, rnd);
    end else begin
      line(VA, 3, rnd);
    end
    line(481, 2, rnd);
    line(524, 2, rnd);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rand_ball"},    int'(rand_ball),     0);
    check({tag, "_upscale"},      int'(upscale),       0);
    check({tag, "_ack"},          int'(new_round_ack), 0);
    check({tag, "_frame_start"},  int'(frame_start),   0);
    check({tag, "_round_active"}, int'(round_active),  0);
    check({tag, "_frames_left"},  int'(frames_left),   0);
  endtask

  initial begin
    // Reset state.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    frame(0, 0);
    frame(0, 0);
    check_reset_values("idle_after_frames");

    // A mid-frame request, then the round counts down.
    @(negedge clk) new_round_req = 1'b1;
    line(50, 2, 0);
    new_round_req = 1'b0;
    frame(0, 0);
    check("t2_round_active", int'(round_active), 1);
    check("t2_frames_left",  int'(frames_left), RF - 1);
    check("t2_ball_nonzero", int'(rand_ball != 2'd0), 1);
    frame(0, 0);
    check("t2_frames_left_1", int'(frames_left), 1);

    // A request in the exact boundary cycle wins over the decrement.
    frame(0, 1);
    check("t4_frames_frozen", int'(frames_left), 1);
    new_round_req = 1'b0;
    frame(0, 0);
    check("t4_reload", int'(frames_left), RF - 1);

    // Upscale change mid-frame, then the round runs out.
    upscale_req = 1'b1;
    repeat (4) frame(0, 0);
    upscale_req = 1'b0;
    frame(0, 0);

    // A held request gives one ack. Reset during a second pending request.
    reset = 1'b1;
    line(0, 2, 0);
    reset = 1'b0;
    @(negedge clk) new_round_req = 1'b1;
    repeat (3) frame(0, 0);
    new_round_req = 1'b0;
    frame(0, 0);
    @(negedge clk) new_round_req = 1'b1;
    line(50, 2, 0);
    reset = 1'b1;
    line(50, 2, 0);
    reset = 1'b0;
    frame(0, 0);
    check_reset_values("t5_after_reset");
    new_round_req = 1'b0;

    // Randomized traffic: requests, upscale toggles, odd lines, resets.
    for (int f = 0; f < 300; f++) frame(1, 0);
    reset = 1'b0;
    new_round_req = 1'b0;
    frame(0, 0);
    frame(0, 0);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
